// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives the request side; slave is the arithmetic unit.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, cin, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, cin, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop,
// LSB first, WIDTH clocks per operation. Subtraction is a + ~b + ~bin.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-2:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_c;
  logic               last;
  logic [WIDTH-1:0]   full_sum;

  // Full-adder slice on the current LSBs and the carry flop.
  always_comb begin
    fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last     = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
    full_sum = {fa_s, sum_q};
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start only matters in IDLE, RUN lasts WIDTH edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, and flag capture on the last bit.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.mode;
          mode_d  = bus.mode;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Only WIDTH-1 sum bits are stored; the final bit goes straight to result.
        sum_d   = sum_q >> 1;
        sum_d[WIDTH-2] = fa_s;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          res_d  = full_sum;
          cout_d = fa_c ^ mode_q;
          ovf_d  = carry_q ^ fa_c;
          zero_d = (full_sum == '0);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: busy from state, everything else from held registers.
  always_comb begin
    bus.busy   = (state_q == RUN);
    bus.done   = done_q;
    bus.result = res_q;
    bus.cout   = cout_q;
    bus.ovf    = ovf_q;
    bus.zero   = zero_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=16.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  bus8 ();
  serial_addsub_if #(.WIDTH(16)) bus16 ();

  serial_addsub #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          lat;
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy8_n = 0;
  int busy16_n = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst) busy8_n = 0;
    else begin
      if (bus8.busy) busy8_n++;
      if (bus8.done) begin
        if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q8.pop_front();
          check({e.name, "_result"}, 64'(bus8.result), e.res);
          check({e.name, "_cout"}, 64'(bus8.cout), 64'(e.cout));
          check({e.name, "_ovf"}, 64'(bus8.ovf), 64'(e.ovf));
          check({e.name, "_zero"}, 64'(bus8.zero), 64'(e.zero));
          check({e.name, "_busy_cycles"}, 64'(busy8_n), 64'(e.lat));
        end
        busy8_n = 0;
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (rst) busy16_n = 0;
    else begin
      if (bus16.busy) busy16_n++;
      if (bus16.done) begin
        if (q16.size() == 0) check("unexpected_done16", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q16.pop_front();
          check({e.name, "_result"}, 64'(bus16.result), e.res);
          check({e.name, "_cout"}, 64'(bus16.cout), 64'(e.cout));
          check({e.name, "_ovf"}, 64'(bus16.ovf), 64'(e.ovf));
          check({e.name, "_zero"}, 64'(bus16.zero), 64'(e.zero));
          check({e.name, "_busy_cycles"}, 64'(busy16_n), 64'(e.lat));
        end
        busy16_n = 0;
      end
    end
  end

  task automatic wait_done8(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.done && n < 40);
    if (!bus8.done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done16(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus16.done && n < 60);
    if (!bus16.done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drive8(input logic m, input logic ci, input logic [7:0] av, input logic [7:0] bv);
    bus8.start = 1'b1;
    bus8.mode  = m;
    bus8.cin   = ci;
    bus8.a     = av;
    bus8.b     = bv;
  endtask

  task automatic op8(input string name, input logic m, input logic ci,
                     input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] r, input logic co, input logic ov, input logic z);
    @(negedge clk);
    drive8(m, ci, av, bv);
    q8.push_back('{64'(r), co, ov, z, 8, name});
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(name);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, 64'(bus8.busy), 64'd0);
    check({name, "_done"}, 64'(bus8.done), 64'd0);
    check({name, "_result"}, 64'(bus8.result), 64'd0);
    check({name, "_cout"}, 64'(bus8.cout), 64'd0);
    check({name, "_ovf"}, 64'(bus8.ovf), 64'd0);
    check({name, "_zero"}, 64'(bus8.zero), 64'd0);
  endtask

  initial begin
    int d1;
    rst = 1'b1;
    bus8.start = 1'b0;  bus8.mode = 1'b0;  bus8.cin = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.cin = 1'b0; bus16.a = '0; bus16.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("reset");

    // Directed arithmetic vectors, expected values computed by hand.
    op8("add_5a_3c",  1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0);
    op8("add_ff_01",  1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("add_00_cin", 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    op8("sub_10_20",  1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
    op8("sub_80_01",  1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("sub_05_bin", 1'b1, 1'b1, 8'h05, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Start while busy is ignored; changing inputs mid-op has no effect.
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h01, 8'h01);
    q8.push_back('{64'h02, 1'b0, 1'b0, 1'b0, 8, "busy_ignore"});
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h7F, 8'h7F);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("busy_ignore");

    // Back-to-back: start presented during the done cycle.
    d1 = cyc;
    drive8(1'b0, 1'b0, 8'h33, 8'h11);
    q8.push_back('{64'h44, 1'b0, 1'b0, 1'b0, 8, "back_to_back"});
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("back_to_back");
    check("done_spacing", 64'(cyc - d1), 64'd9);

    // Reset mid-operation: no done, all outputs cleared.
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h5A, 8'h3C);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("mid_reset");
    repeat (12) @(negedge clk);
    check("mid_reset_no_done_pending", 64'(q8.size()), 64'd0);

    op8("add_01_02", 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);

    // 16-bit instance: full carry ripple across the word.
    @(negedge clk);
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.cin = 1'b0;
    bus16.a = 16'hFFFF; bus16.b = 16'h0001;
    q16.push_back('{64'h0000, 1'b1, 1'b0, 1'b1, 16, "w16_ffff_0001"});
    @(negedge clk);
    bus16.start = 1'b0;
    wait_done16("w16_ffff_0001");

    repeat (4) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
